// File: rtl/vga_board_arbiter_if.sv
// Bus bundle between the board RAM arbiter, the snake engine, the board RAM and the pixel stage.
// The arbiter connects through the slave modport; the environment around it uses the master modport.
interface vga_board_arbiter_if #(
  parameter int ADDR_W = 10
) ();
  logic [9:0]        HS_cnt;
  logic [9:0]        VS_cnt;
  logic              eng_req;
  logic              eng_we;
  logic [ADDR_W-1:0] eng_addr;
  logic [1:0]        eng_wdata;
  logic              eng_gnt;
  logic              eng_rvalid;
  logic [1:0]        eng_rdata;
  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [1:0]        ram_wdata;
  logic [1:0]        ram_rdata;
  logic              pix_valid;
  logic [1:0]        cell_code;
  logic [4:0]        cell_px;
  logic [4:0]        cell_py;

  modport slave (
    input  HS_cnt, VS_cnt, eng_req, eng_we, eng_addr, eng_wdata, ram_rdata,
    output eng_gnt, eng_rvalid, eng_rdata, ram_en, ram_we, ram_addr, ram_wdata,
           pix_valid, cell_code, cell_px, cell_py
  );

  modport master (
    output HS_cnt, VS_cnt, eng_req, eng_we, eng_addr, eng_wdata, ram_rdata,
    input  eng_gnt, eng_rvalid, eng_rdata, ram_en, ram_we, ram_addr, ram_wdata,
           pix_valid, cell_code, cell_px, cell_py
  );
endinterface

// File: rtl/vga_board_arbiter.sv
// Shares the single-port board RAM between the display fetch and the snake engine.
// Define VBLANK_ONLY_WR_EN to restrict engine writes to vertical blanking.
module vga_board_arbiter #(
  parameter int H_ACT_START = 144,
  parameter int V_ACT_START = 32,
  parameter int H_CELLS     = 32,
  parameter int V_CELLS     = 24,
  parameter int CELL_PX     = 20,
  parameter int ADDR_W      = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  vga_board_arbiter_if.slave bus
);

  typedef enum logic [1:0] {OWN_NONE, OWN_DISP, OWN_ENG} owner_t;

  localparam logic [10:0]     H_START = 11'(H_ACT_START);
  localparam logic [10:0]     H_END   = 11'(H_ACT_START + H_CELLS * CELL_PX);
  localparam logic [10:0]     V_START = 11'(V_ACT_START);
  localparam logic [10:0]     V_END   = 11'(V_ACT_START + V_CELLS * CELL_PX);
  localparam logic [4:0]      PX_LAST = 5'(CELL_PX - 1);
  localparam logic [ADDR_W:0] N_CELLS = (ADDR_W + 1)'(H_CELLS * V_CELLS);

  logic [10:0]       h_cur, h_nxt, v_cur;
  logic              v_act, act_n, line_start, line_end;
  logic              fetch_n, in_range, wr_ok;
  logic              act, act_d;
  logic [4:0]        cx, col, cy, cx_d, cy_d;
  logic [4:0]        cx_n, col_n, cy_n;
  logic [ADDR_W-1:0] row_base, row_base_n;
  logic              acc_disp, acc_rd;
  owner_t            owner;

  // The RAM strobes are registered, so decisions are made for the pixel arriving next cycle.
  assign h_cur      = {1'b0, bus.HS_cnt};
  assign h_nxt      = h_cur + 11'd1;
  assign v_cur      = {1'b0, bus.VS_cnt};
  assign v_act      = (v_cur >= V_START) && (v_cur < V_END);
  assign act_n      = v_act && (h_nxt >= H_START) && (h_nxt < H_END);
  assign line_start = (h_nxt == H_START);
  assign line_end   = (h_cur == H_END - 11'd1);
  assign fetch_n    = act_n && (cx_n == 5'd0);
  assign in_range   = ({1'b0, bus.eng_addr} < N_CELLS);

`ifdef VBLANK_ONLY_WR_EN
  assign wr_ok = !bus.eng_we || !v_act;
`else
  assign wr_ok = 1'b1;
`endif

  always_comb begin
    cx_n       = cx;
    col_n      = col;
    cy_n       = cy;
    row_base_n = row_base;
    if (line_start) begin
      cx_n  = 5'd0;
      col_n = 5'd0;
    end else if (act_n) begin
      if (cx == PX_LAST) begin
        cx_n  = 5'd0;
        col_n = col + 5'd1;
      end else begin
        cx_n = cx + 5'd1;
      end
    end
    // Row base steps by a full row of cells so the fetch address needs no multiplier.
    if (line_start && (v_cur == V_START)) begin
      cy_n       = 5'd0;
      row_base_n = '0;
    end else if (line_end && v_act) begin
      if (cy == PX_LAST) begin
        cy_n       = 5'd0;
        row_base_n = row_base + ADDR_W'(H_CELLS);
      end else begin
        cy_n = cy + 5'd1;
      end
    end
  end

  assign bus.eng_rdata = (owner == OWN_ENG) ? bus.ram_rdata : 2'b00;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      act           <= 1'b0;
      act_d         <= 1'b0;
      cx            <= '0;
      col           <= '0;
      cy            <= '0;
      cx_d          <= '0;
      cy_d          <= '0;
      row_base      <= '0;
      acc_disp      <= 1'b0;
      acc_rd        <= 1'b0;
      owner         <= OWN_NONE;
      bus.eng_gnt   <= 1'b0;
      bus.eng_rvalid <= 1'b0;
      bus.ram_en    <= 1'b0;
      bus.ram_we    <= 1'b0;
      bus.ram_addr  <= '0;
      bus.ram_wdata <= '0;
      bus.pix_valid <= 1'b0;
      bus.cell_code <= '0;
      bus.cell_px   <= '0;
      bus.cell_py   <= '0;
    end else begin
      act      <= act_n;
      cx       <= cx_n;
      col      <= col_n;
      cy       <= cy_n;
      row_base <= row_base_n;
      act_d    <= act;
      cx_d     <= cx;
      cy_d     <= cy;

      bus.pix_valid <= act_d;
      bus.cell_px   <= act_d ? cx_d : 5'd0;
      bus.cell_py   <= act_d ? cy_d : 5'd0;
      if (!act_d)
        bus.cell_code <= 2'b00;
      else if (owner == OWN_DISP)
        bus.cell_code <= bus.ram_rdata;

      owner <= !bus.ram_en ? OWN_NONE : (acc_disp ? OWN_DISP : OWN_ENG);
      bus.eng_rvalid <= acc_rd;

      bus.eng_gnt   <= 1'b0;
      bus.ram_en    <= 1'b0;
      bus.ram_we    <= 1'b0;
      bus.ram_addr  <= '0;
      bus.ram_wdata <= '0;
      acc_disp      <= 1'b0;
      acc_rd        <= 1'b0;
      // Display fetch always wins; an out-of-range engine address is granted without touching RAM.
      if (fetch_n) begin
        bus.ram_en   <= 1'b1;
        bus.ram_addr <= row_base_n + ADDR_W'(col_n);
        acc_disp     <= 1'b1;
      end else if (bus.eng_req && wr_ok) begin
        bus.eng_gnt   <= 1'b1;
        bus.ram_en    <= in_range;
        bus.ram_we    <= bus.eng_we && in_range;
        bus.ram_addr  <= bus.eng_addr;
        bus.ram_wdata <= bus.eng_wdata;
        acc_rd        <= !bus.eng_we;
      end
    end
  end

endmodule

// File: tb/tb_vga_board_arbiter.sv
// Directed bench for vga_board_arbiter with a one-cycle-latency RAM model and a bench-driven scan position.
// Build with +define+VBLANK_ONLY_WR_EN to exercise the blanking-only write variant.
module tb_vga_board_arbiter;

  logic clk;
  logic rst_n;
  int   hs, vs;
  int   n_checks;
  int   n_fail;
  logic [1:0] mem [0:1023];

  vga_board_arbiter_if bus ();

  vga_board_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Board RAM model: read data appears the cycle after ram_en.
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 2'b00;
      bus.ram_rdata <= 2'b00;
    end else if (bus.ram_en) begin
      if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
      bus.ram_rdata <= mem[bus.ram_addr];
    end
  end

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic apply_stimulus(input logic req, input logic we, input int addr, input logic [1:0] wdata);
    bus.eng_req   = req;
    bus.eng_we    = we;
    bus.eng_addr  = 10'(addr);
    bus.eng_wdata = wdata;
  endtask

  task automatic set_pos(input int h, input int v);
    hs = h;
    vs = v;
    bus.HS_cnt = 10'(hs);
    bus.VS_cnt = 10'(vs);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
    if (hs == 799) begin
      hs = 0;
      vs = (vs == 520) ? 0 : vs + 1;
    end else begin
      hs = hs + 1;
    end
    bus.HS_cnt = 10'(hs);
    bus.VS_cnt = 10'(vs);
  endtask

  task automatic run_to(input int h, input int v);
    int n;
    n = 0;
    while (!(hs == h && vs == v) && n < 30000) begin
      tick();
      n++;
    end
  endtask

  task automatic eng_write(input int addr, input logic [1:0] data);
    apply_stimulus(1'b1, 1'b1, addr, data);
    tick();
    check_output("wr_gnt", 32'(bus.eng_gnt), 32'd1);
    apply_stimulus(1'b0, 1'b0, 0, 2'b00);
    tick();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    set_pos(0, 0);
    apply_stimulus(1'b1, 1'b1, 5, 2'b11);

    // Reset held with a pending write request
    tick();
    check_output("rst_gnt0", 32'(bus.eng_gnt), 32'd0);
    tick();
    check_output("rst_gnt1", 32'(bus.eng_gnt), 32'd0);
    tick();
    check_output("rst_gnt2", 32'(bus.eng_gnt), 32'd0);
    check_output("rst_ram_en", 32'(bus.ram_en), 32'd0);
    check_output("rst_pix_valid", 32'(bus.pix_valid), 32'd0);
    check_output("rst_rvalid", 32'(bus.eng_rvalid), 32'd0);
    check_output("rst_cell_code", 32'(bus.cell_code), 32'd0);
    check_output("rst_rdata", 32'(bus.eng_rdata), 32'd0);
    rst_n = 1'b1;

    // First grant: write addr 5 data 11
    tick();
    check_output("w5_gnt", 32'(bus.eng_gnt), 32'd1);
    check_output("w5_ram_en", 32'(bus.ram_en), 32'd1);
    check_output("w5_ram_we", 32'(bus.ram_we), 32'd1);
    check_output("w5_ram_addr", 32'(bus.ram_addr), 32'd5);
    check_output("w5_ram_wdata", 32'(bus.ram_wdata), 32'd3);
    apply_stimulus(1'b0, 1'b0, 0, 2'b00);
    tick();
    check_output("w5_gnt_drop", 32'(bus.eng_gnt), 32'd0);
    check_output("w5_no_rvalid", 32'(bus.eng_rvalid), 32'd0);

    eng_write(1, 2'b10);
    eng_write(31, 2'b11);

    // Engine read of addr 5
    apply_stimulus(1'b1, 1'b0, 5, 2'b00);
    tick();
    check_output("r5_gnt", 32'(bus.eng_gnt), 32'd1);
    check_output("r5_ram_we", 32'(bus.ram_we), 32'd0);
    apply_stimulus(1'b0, 1'b0, 0, 2'b00);
    tick();
    check_output("r5_rvalid", 32'(bus.eng_rvalid), 32'd1);
    check_output("r5_rdata", 32'(bus.eng_rdata), 32'd3);
    tick();
    check_output("r5_rvalid_drop", 32'(bus.eng_rvalid), 32'd0);

    // Out-of-range read
    apply_stimulus(1'b1, 1'b0, 800, 2'b00);
    tick();
    check_output("r800_gnt", 32'(bus.eng_gnt), 32'd1);
    check_output("r800_ram_en", 32'(bus.ram_en), 32'd0);
    apply_stimulus(1'b0, 1'b0, 0, 2'b00);
    tick();
    check_output("r800_rvalid", 32'(bus.eng_rvalid), 32'd1);
    check_output("r800_rdata", 32'(bus.eng_rdata), 32'd0);

    // Back-to-back reads of addr 1
    apply_stimulus(1'b1, 1'b0, 1, 2'b00);
    tick();
    check_output("b2b_gnt0", 32'(bus.eng_gnt), 32'd1);
    tick();
    check_output("b2b_gnt1", 32'(bus.eng_gnt), 32'd1);
    check_output("b2b_rdata0", 32'(bus.eng_rdata), 32'd2);
    apply_stimulus(1'b0, 1'b0, 0, 2'b00);
    tick();
    check_output("b2b_gnt_drop", 32'(bus.eng_gnt), 32'd0);
    check_output("b2b_rvalid1", 32'(bus.eng_rvalid), 32'd1);

    // Display fetch of cell 1 on line 32, engine read raised in the fetch cycle
    set_pos(140, 32);
    run_to(164, 32);
    check_output("f1_ram_en", 32'(bus.ram_en), 32'd1);
    check_output("f1_ram_addr", 32'(bus.ram_addr), 32'd1);
    check_output("f1_gnt", 32'(bus.eng_gnt), 32'd0);
    apply_stimulus(1'b1, 1'b0, 5, 2'b00);
    tick();
    check_output("f1_eng_gnt", 32'(bus.eng_gnt), 32'd1);
    check_output("f1_eng_addr", 32'(bus.ram_addr), 32'd5);
    check_output("f1_prev_px", 32'(bus.cell_px), 32'd19);
    check_output("f1_prev_code", 32'(bus.cell_code), 32'd0);
    apply_stimulus(1'b0, 1'b0, 0, 2'b00);
    tick();
    check_output("f1_code", 32'(bus.cell_code), 32'd2);
    check_output("f1_px", 32'(bus.cell_px), 32'd0);
    check_output("f1_py", 32'(bus.cell_py), 32'd0);
    check_output("f1_pix_valid", 32'(bus.pix_valid), 32'd1);
    check_output("f1_rvalid", 32'(bus.eng_rvalid), 32'd1);
    check_output("f1_rdata", 32'(bus.eng_rdata), 32'd3);

    // Engine request colliding with the fetch of cell 2 is deferred one cycle
    run_to(183, 32);
    apply_stimulus(1'b1, 1'b0, 1, 2'b00);
    tick();
    check_output("c2_gnt_held", 32'(bus.eng_gnt), 32'd0);
    check_output("c2_ram_addr", 32'(bus.ram_addr), 32'd2);
    tick();
    check_output("c2_gnt", 32'(bus.eng_gnt), 32'd1);
    check_output("c2_eng_addr", 32'(bus.ram_addr), 32'd1);
    check_output("c1_hold_code", 32'(bus.cell_code), 32'd2);
    check_output("c1_hold_px", 32'(bus.cell_px), 32'd19);
    apply_stimulus(1'b0, 1'b0, 0, 2'b00);
    tick();
    check_output("c2_rvalid", 32'(bus.eng_rvalid), 32'd1);
    check_output("c2_rdata", 32'(bus.eng_rdata), 32'd2);
    check_output("c2_code", 32'(bus.cell_code), 32'd0);
    check_output("c2_px", 32'(bus.cell_px), 32'd0);

    // Right edge of the active area
    run_to(785, 32);
    check_output("edge_valid", 32'(bus.pix_valid), 32'd1);
    check_output("edge_code", 32'(bus.cell_code), 32'd3);
    check_output("edge_px", 32'(bus.cell_px), 32'd19);
    tick();
    check_output("blank_valid", 32'(bus.pix_valid), 32'd0);
    check_output("blank_code", 32'(bus.cell_code), 32'd0);
    check_output("blank_px", 32'(bus.cell_px), 32'd0);

    // Second line of row 0, then first line of row 1
    run_to(164, 33);
    check_output("l33_ram_addr", 32'(bus.ram_addr), 32'd1);
    run_to(166, 33);
    check_output("l33_py", 32'(bus.cell_py), 32'd1);
    check_output("l33_code", 32'(bus.cell_code), 32'd2);
    run_to(164, 52);
    check_output("row1_ram_en", 32'(bus.ram_en), 32'd1);
    check_output("row1_ram_addr", 32'(bus.ram_addr), 32'd33);
    run_to(166, 52);
    check_output("row1_py", 32'(bus.cell_py), 32'd0);

    // Engine write during the active frame
    set_pos(10, 100);
    apply_stimulus(1'b1, 1'b1, 7, 2'b01);
    tick();
`ifdef VBLANK_ONLY_WR_EN
    check_output("vb_wr_block0", 32'(bus.eng_gnt), 32'd0);
    tick();
    check_output("vb_wr_block1", 32'(bus.eng_gnt), 32'd0);
    tick();
    check_output("vb_wr_block2", 32'(bus.eng_gnt), 32'd0);
    set_pos(0, 512);
    tick();
    check_output("vb_wr_gnt", 32'(bus.eng_gnt), 32'd1);
    check_output("vb_wr_we", 32'(bus.ram_we), 32'd1);
    check_output("vb_wr_addr", 32'(bus.ram_addr), 32'd7);
    apply_stimulus(1'b0, 1'b0, 0, 2'b00);
    tick();
    set_pos(10, 100);
`else
    check_output("act_wr_gnt", 32'(bus.eng_gnt), 32'd1);
    check_output("act_wr_we", 32'(bus.ram_we), 32'd1);
    apply_stimulus(1'b0, 1'b0, 0, 2'b00);
    tick();
`endif
    apply_stimulus(1'b1, 1'b0, 7, 2'b00);
    tick();
    check_output("act_rd_gnt", 32'(bus.eng_gnt), 32'd1);
    apply_stimulus(1'b0, 1'b0, 0, 2'b00);
    tick();
    check_output("act_rd_rvalid", 32'(bus.eng_rvalid), 32'd1);
    check_output("act_rd_rdata", 32'(bus.eng_rdata), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
